// File: rtl/hack_video_pkg.sv
// Shared constants and types for the Hack screen scanout: 640x480@60 VGA
// timing, the 512x256 monochrome framebuffer geometry and counter widths.
package hack_video_pkg;

  localparam int H_VISIBLE = 640;
  localparam int H_FRONT   = 16;
  localparam int H_SYNC    = 96;
  localparam int H_BACK    = 48;
  localparam int H_TOTAL   = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;

  localparam int V_VISIBLE = 480;
  localparam int V_FRONT   = 10;
  localparam int V_SYNC    = 2;
  localparam int V_BACK    = 33;

  localparam int FB_WIDTH      = 512;
  localparam int FB_HEIGHT     = 256;
  localparam int FB_ROW_WORDS  = 32;
  localparam int WORD_BITS     = 16;

  localparam int HCOUNT_W = 10;
  localparam int VCOUNT_W = 10;
  localparam int ROW_W    = 8;
  localparam int GROUP_W  = 5;
  localparam int ADDR_W   = ROW_W + GROUP_W;

  typedef logic [HCOUNT_W-1:0]  hcount_t;
  typedef logic [VCOUNT_W-1:0]  vcount_t;
  typedef logic [ADDR_W-1:0]    vaddr_t;
  typedef logic [WORD_BITS-1:0] vword_t;

endpackage

// File: rtl/hack_screen_scanout_if.sv
// VRAM pixel-port bundle: the scanout is the master issuing single-cycle
// reads, the video RAM is the slave returning data three cycles later.
interface hack_screen_scanout_if;
  import hack_video_pkg::*;

  logic   p_read;
  vaddr_t p_addr;
  vword_t p_dout;

  modport master (output p_read, output p_addr, input p_dout);
  modport slave  (input p_read, input p_addr, output p_dout);

endinterface

// File: rtl/vga_timing.sv
// VGA raster counters with registered sync and frame_start outputs; the
// visible flag is combinational on the current counters.
module vga_timing
  import hack_video_pkg::*;
#(
  parameter int V_ACTIVE = V_VISIBLE,
  parameter int V_FPORCH = V_FRONT,
  parameter int V_SWIDTH = V_SYNC,
  parameter int V_BPORCH = V_BACK
) (
  input  logic    clk,
  input  logic    resetn,
  output hcount_t hcount,
  output vcount_t vcount,
  output logic    visible,
  output logic    hsync,
  output logic    vsync,
  output logic    frame_start
);

  localparam hcount_t H_LAST   = hcount_t'(H_TOTAL - 1);
  localparam hcount_t HS_START = hcount_t'(H_VISIBLE + H_FRONT);
  localparam hcount_t HS_END   = hcount_t'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam hcount_t H_VIS    = hcount_t'(H_VISIBLE);
  localparam vcount_t V_LAST   = vcount_t'(V_ACTIVE + V_FPORCH + V_SWIDTH + V_BPORCH - 1);
  localparam vcount_t VS_START = vcount_t'(V_ACTIVE + V_FPORCH);
  localparam vcount_t VS_END   = vcount_t'(V_ACTIVE + V_FPORCH + V_SWIDTH);
  localparam vcount_t V_VIS    = vcount_t'(V_ACTIVE);

  assign visible = (hcount < H_VIS) && (vcount < V_VIS);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      hcount      <= '0;
      vcount      <= '0;
      hsync       <= 1'b1;
      vsync       <= 1'b1;
      frame_start <= 1'b0;
    end else begin
      if (hcount == H_LAST) begin
        hcount <= '0;
        vcount <= (vcount == V_LAST) ? '0 : vcount + vcount_t'(1);
      end else begin
        hcount <= hcount + hcount_t'(1);
      end
      hsync       <= !((hcount >= HS_START) && (hcount < HS_END));
      vsync       <= !((vcount >= VS_START) && (vcount < VS_END));
      frame_start <= (hcount == '0) && (vcount == '0);
    end
  end

endmodule

// File: rtl/hack_screen_scanout.sv
// Hack framebuffer scanout: VRAM word fetch, 16-bit serialiser and video mux.
// Build option HACK_SCANOUT_BORDER_EN lights visible pixels outside the window.
module hack_screen_scanout
  import hack_video_pkg::*;
#(
  parameter int X0         = 64,
  parameter int Y0         = 112,
  parameter int FETCH_LEAD = 8,
  parameter int V_ACTIVE   = V_VISIBLE,
  parameter int V_FPORCH   = V_FRONT,
  parameter int V_SWIDTH   = V_SYNC,
  parameter int V_BPORCH   = V_BACK
) (
  input  logic                   clk,
  input  logic                   resetn,
  hack_screen_scanout_if.master  vram,
  output logic                   hsync,
  output logic                   vsync,
  output logic                   video,
  output logic                   frame_start
);

`ifdef HACK_SCANOUT_BORDER_EN
  localparam logic BORDER = 1'b1;
`else
  localparam logic BORDER = 1'b0;
`endif

  localparam hcount_t WIN_X0   = hcount_t'(X0);
  localparam hcount_t WIN_X1   = hcount_t'(X0 + FB_WIDTH);
  localparam vcount_t WIN_Y0   = vcount_t'(Y0);
  localparam vcount_t WIN_Y1   = vcount_t'(Y0 + FB_HEIGHT);
  localparam hcount_t FETCH_X0 = hcount_t'(X0 - FETCH_LEAD);
  localparam hcount_t FETCH_X1 = hcount_t'(X0 - FETCH_LEAD + FB_WIDTH);
  localparam vcount_t V_VIS    = vcount_t'(V_ACTIVE);

  hcount_t            hcount;
  vcount_t            vcount;
  logic               visible;
  hcount_t            hnext;
  logic [8:0]         fx;
  logic [3:0]         wx_lo;
  logic [ROW_W-1:0]   row;
  logic               win_line;
  logic               in_win;
  logic               fetch_next;
  logic               load;
  logic [2:0]         rd_pipe;
  vword_t             hold;
  vword_t             shift;
  vword_t             shift_next;
  logic               pix;

  vga_timing #(
    .V_ACTIVE (V_ACTIVE),
    .V_FPORCH (V_FPORCH),
    .V_SWIDTH (V_SWIDTH),
    .V_BPORCH (V_BPORCH)
  ) u_timing (
    .clk         (clk),
    .resetn      (resetn),
    .hcount      (hcount),
    .vcount      (vcount),
    .visible     (visible),
    .hsync       (hsync),
    .vsync       (vsync),
    .frame_start (frame_start)
  );

  // Fetches are decided one pixel early so the registered strobe lands on
  // its own hcount; fetch points never straddle a line end.
  assign hnext      = hcount + hcount_t'(1);
  assign fx         = 9'(hnext - FETCH_X0);
  assign wx_lo      = 4'(hcount - WIN_X0);
  assign row        = ROW_W'(vcount - WIN_Y0);
  assign win_line   = (vcount >= WIN_Y0) && (vcount < WIN_Y1);
  assign in_win     = win_line && (hcount >= WIN_X0) && (hcount < WIN_X1);
  assign fetch_next = win_line && (vcount < V_VIS) &&
                      (hnext >= FETCH_X0) && (hnext < FETCH_X1) && (fx[3:0] == 4'd0);
  assign load       = in_win && (wx_lo == 4'd0);

  // Rotating keeps every bit live; within a group it matches a plain shift.
  assign shift_next = load ? hold : {shift[0], shift[WORD_BITS-1:1]};

  always_comb begin
    pix = 1'b0;
    if (visible) pix = in_win ? ~shift_next[0] : BORDER;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      vram.p_read <= 1'b0;
      vram.p_addr <= '0;
      rd_pipe     <= '0;
      hold        <= '0;
      shift       <= '0;
      video       <= 1'b0;
    end else begin
      vram.p_read <= fetch_next;
      if (fetch_next) vram.p_addr <= {row, fx[8:4]};
      rd_pipe <= {rd_pipe[1:0], vram.p_read};
      if (rd_pipe[2]) hold <= vram.p_dout;
      shift <= shift_next;
      video <= pix;
    end
  end

endmodule
